// File: rtl/decoder_scan_sequencer_pkg.sv
// scan_pkg: shared state encoding and digit geometry for the scan sequencer and decoder benches.
// Exports state_t (IDLE, ACTIVE, BLANK), SEL_W (select width) and NUM_DIGITS (mask width).
package scan_pkg;
   localparam int SEL_W = 3;
   localparam int NUM_DIGITS = 8;
   typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;
endpackage

// File: rtl/decoder_scan_sequencer_mask_next_index.sv
// mask_next_index: picks the next enabled digit above cur, wrapping to the lowest enabled digit.
// Ports: mask (digit enables), cur (current index) -> nxt (next index), wrap (nxt <= cur), any_set (mask != 0).
module mask_next_index
   import scan_pkg::*;
(
   input  logic [NUM_DIGITS-1:0] mask,
   input  logic [SEL_W-1:0]      cur,
   output logic [SEL_W-1:0]      nxt,
   output logic                  wrap,
   output logic                  any_set
);
   logic [SEL_W-1:0] low, high;
   logic found;
   // Descending scan: the last hit written is the lowest qualifying index.
   always_comb begin
      low = '0;
      high = '0;
      found = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (mask[i]) low = SEL_W'(i);
         if (mask[i] && SEL_W'(i) > cur) begin
            high = SEL_W'(i);
            found = 1'b1;
         end
      end
   end
   assign any_set = |mask;
   assign nxt = found ? high : low;
   assign wrap = !found;
endmodule

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: drives 3-to-8 decoder select/enable, dwelling on each masked digit with blanking gaps.
// Ports: clk, rst (sync, active-high), run, mask -> sel ({a,b,c}), en (e), tick (digit start), frame_done (wrap).
module decoder_scan_sequencer
   import scan_pkg::*;
#(
   parameter int PRESCALE = 100000,
   parameter int BLANK_CYCLES = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic [NUM_DIGITS-1:0] mask,
   output logic [SEL_W-1:0]      sel,
   output logic                  en,
   output logic                  tick,
   output logic                  frame_done
);
   localparam int CW = $clog2((PRESCALE > BLANK_CYCLES ? PRESCALE : BLANK_CYCLES) + 1);
   localparam logic [CW-1:0] P_LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
   state_t state;
   logic [CW-1:0] cnt;
   logic [SEL_W-1:0] cur, nxt;
   logic wrap, any_set;
   // From IDLE, presenting the top index makes the selector return the lowest set bit.
   assign cur = (state == IDLE) ? SEL_W'(NUM_DIGITS - 1) : sel;
   mask_next_index u_next (
      .mask    (mask),
      .cur     (cur),
      .nxt     (nxt),
      .wrap    (wrap),
      .any_set (any_set)
   );
   always_ff @(posedge clk) begin
      tick <= 1'b0;
      frame_done <= 1'b0;
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         sel <= '0;
         en <= 1'b0;
      end else if (!run) begin
         state <= IDLE;
         cnt <= '0;
         en <= 1'b0;
      end else if ((state == ACTIVE && cnt != P_LAST) || (state == BLANK && cnt != B_LAST)) begin
         cnt <= cnt + CW'(1);
      end else if (state == ACTIVE && BLANK_CYCLES != 0) begin
         state <= BLANK;
         en <= 1'b0;
         cnt <= '0;
      end else if (any_set) begin
         // Digit start: entry from IDLE never reports a frame wrap.
         state <= ACTIVE;
         sel <= nxt;
         en <= 1'b1;
         tick <= 1'b1;
         frame_done <= wrap && state != IDLE;
         cnt <= '0;
      end else begin
         state <= IDLE;
         en <= 1'b0;
         cnt <= '0;
      end
   end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: directed plus random checks of two sequencer builds against a period-position model.
module tb_decoder_scan_sequencer;
   localparam int P = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b1;
   logic [7:0] mask = 8'hFF;
   logic [2:0] sel0, sel1;
   logic en0, en1, tick0, tick1, fd0, fd1;
   int vectors = 0;
   int miscompares = 0;
   logic [2:0] m_sel[2];
   bit m_on[2], m_en[2], m_tick[2], m_fd[2];
   int m_pos[2];
   always #5 clk = ~clk;
   decoder_scan_sequencer #(.PRESCALE(P), .BLANK_CYCLES(2)) dut0 (
      .clk(clk), .rst(rst), .run(run), .mask(mask),
      .sel(sel0), .en(en0), .tick(tick0), .frame_done(fd0)
   );
   decoder_scan_sequencer #(.PRESCALE(P), .BLANK_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .run(run), .mask(mask),
      .sel(sel1), .en(en1), .tick(tick1), .frame_done(fd1)
   );
   function automatic int next_digit(input logic [7:0] m, input int cur);
      for (int i = 1; i <= 8; i++) if (m[(cur + i + 8) % 8]) return (cur + i + 8) % 8;
      return 0;
   endfunction
   // Model: one position counter across the whole digit period; en is high for the first P positions.
   task automatic step(input int k);
      int b = (k == 0) ? 2 : 0;
      int j;
      m_tick[k] = 0;
      m_fd[k] = 0;
      if (rst) begin
         m_on[k] = 0; m_sel[k] = 0; m_pos[k] = 0; m_en[k] = 0;
      end else if (!run) begin
         m_on[k] = 0; m_pos[k] = 0; m_en[k] = 0;
      end else if (!m_on[k] || m_pos[k] + 1 == P + b) begin
         if (mask == 8'h00) begin
            m_on[k] = 0; m_pos[k] = 0; m_en[k] = 0;
         end else begin
            j = next_digit(mask, m_on[k] ? int'(m_sel[k]) : -1);
            m_fd[k] = m_on[k] && j <= int'(m_sel[k]);
            m_sel[k] = 3'(j);
            m_on[k] = 1; m_pos[k] = 0; m_en[k] = 1; m_tick[k] = 1;
         end
      end else begin
         m_pos[k]++;
         m_en[k] = m_pos[k] < P;
      end
   endtask
   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input string tag);
      @(posedge clk);
      step(0);
      step(1);
      #1;
      chk({tag, "_b2"}, {sel0, en0, tick0, fd0}, {m_sel[0], m_en[0], m_tick[0], m_fd[0]});
      chk({tag, "_b0"}, {sel1, en1, tick1, fd1}, {m_sel[1], m_en[1], m_tick[1], m_fd[1]});
   endtask
   task automatic bound_chk(input string tag, input bit ok);
      vectors++;
      assert (ok) else begin
         miscompares++;
         $error("FAIL %s observed=timeout expected=event", tag);
      end
   endtask
   initial begin
      int t_tick, t_fd;
      bit ok;
      for (int i = 0; i < 3; i++) cyc("reset");
      rst = 1'b0;
      t_tick = -1;
      t_fd = -1;
      for (int i = 0; i < 70; i++) begin
         cyc("full_scan");
         if (tick0 && t_tick < 0) t_tick = i;
         if (fd0 && t_fd < 0) t_fd = i;
      end
      vectors++;
      assert (t_fd - t_tick === 48) else begin
         miscompares++;
         $error("FAIL frame_gap observed=%0d expected=48", t_fd - t_tick);
      end
      mask = 8'b1010_0100;
      for (int i = 0; i < 40; i++) cyc("sparse");
      mask = 8'h10;
      for (int i = 0; i < 24; i++) cyc("single");
      mask = 8'hFF;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         cyc("seek3");
         ok = m_tick[0] && m_sel[0] == 3'd3;
      end
      bound_chk("seek3", ok);
      cyc("digit3_second");
      run = 1'b0;
      cyc("run_drop");
      cyc("run_idle");
      run = 1'b1;
      for (int i = 0; i < 10; i++) cyc("restart");
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         cyc("seek_blank");
         ok = m_on[0] && m_pos[0] == P;
      end
      bound_chk("seek_blank", ok);
      mask = 8'h00;
      for (int i = 0; i < 6; i++) cyc("mask_zero");
      mask = 8'h5A;
      for (int i = 0; i < 2; i++) cyc("resume");
      rst = 1'b1;
      cyc("rst_mid");
      rst = 1'b0;
      for (int i = 0; i < 8; i++) cyc("post_rst");
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(15) == 0) mask = ($urandom_range(3) == 0) ? 8'(1 << $urandom_range(7)) : 8'($urandom);
         run = $urandom_range(39) != 0;
         rst = $urandom_range(199) == 0;
         cyc("random");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
